lcd_write_sequencer: RTL and testbench

Sequences all writes to the character LCD's 8-bit HD44780 bus. After reset it runs the fixed power-on initialisation sequence, then accepts single-byte command/data writes from upstream display logic over a valid/ready handshake. For each write it generates the RS/data setup, E pulse, hold and controller execution wait at cycle accuracy. It sits between the display content logic and the LCD_* pins of the top level, and it is the only driver of those pins.

---
 rtl/lcd_write_sequencer.sv | 159 +++++++++++++++
 tb/tb_lcd_write_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_sequencer.sv
// HD44780 8-bit write sequencer: power-on init, then single-byte
// command/data writes with cycle-accurate setup, E pulse, hold and exec wait.
module lcd_write_sequencer #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_INIT1   = 205000,
  parameter int unsigned T_INIT2   = 5000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PULSE   = 12,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_EXEC    = 2000,
  parameter int unsigned T_CLEAR   = 82000
) (
  input  logic       CLOCK_50MHZ,
  input  logic       BUTTON_SOUTH,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic [7:0] LCD_DATA_BIT,
  output logic       LCD_ENABLE,
  output logic       LCD_REGISTER_SELECT,
  output logic       LCD_READ_WRITE
);

  typedef enum logic [2:0] {
    POWERUP,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    IDLE
  } state_t;

  // terminal counts: counter runs 0..T-1 in each state
  localparam logic [19:0] M_POWERUP = 20'(T_POWERUP - 1);
  localparam logic [19:0] M_INIT1   = 20'(T_INIT1 - 1);
  localparam logic [19:0] M_INIT2   = 20'(T_INIT2 - 1);
  localparam logic [19:0] M_SETUP   = 20'(T_SETUP - 1);
  localparam logic [19:0] M_PULSE   = 20'(T_PULSE - 1);
  localparam logic [19:0] M_HOLD    = 20'(T_HOLD - 1);
  localparam logic [19:0] M_EXEC    = 20'(T_EXEC - 1);
  localparam logic [19:0] M_CLEAR   = 20'(T_CLEAR - 1);
  localparam logic [2:0]  LAST_INIT = 3'd6;

  state_t      state;
  logic [19:0] cnt;
  logic [19:0] wait_m;
  logic [2:0]  idx;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd4:    return 8'h06;
      3'd5:    return 8'h0C;
      3'd6:    return 8'h01;
      default: return 8'h38;
    endcase
  endfunction

  function automatic logic [19:0] init_wait(input logic [2:0] i);
    case (i)
      3'd0:    return M_INIT1;
      3'd1:    return M_INIT2;
      3'd6:    return M_CLEAR;
      default: return M_EXEC;
    endcase
  endfunction

  // clear display / return home need the long execution time
  function automatic logic [19:0] user_wait(
    input logic       rs,
    input logic [7:0] d
  );
    if (!rs && (d inside {8'h01, 8'h02, 8'h03}))
      return M_CLEAR;
    return M_EXEC;
  endfunction

  always_ff @(posedge CLOCK_50MHZ) begin
    if (BUTTON_SOUTH) begin
      state               <= POWERUP;
      cnt                 <= '0;
      wait_m              <= '0;
      idx                 <= '0;
      req_ready           <= 1'b0;
      init_done           <= 1'b0;
      LCD_DATA_BIT        <= 8'h00;
      LCD_ENABLE          <= 1'b0;
      LCD_REGISTER_SELECT <= 1'b0;
      LCD_READ_WRITE      <= 1'b0;
    end else begin
      cnt            <= cnt + 20'd1;
      LCD_READ_WRITE <= 1'b0;
      unique case (state)
        POWERUP: begin
          if (cnt == M_POWERUP) begin
            state               <= SETUP;
            cnt                 <= '0;
            idx                 <= '0;
            LCD_DATA_BIT        <= init_byte(3'd0);
            LCD_REGISTER_SELECT <= 1'b0;
            wait_m              <= init_wait(3'd0);
          end
        end
        SETUP: begin
          if (cnt == M_SETUP) begin
            state      <= PULSE;
            cnt        <= '0;
            LCD_ENABLE <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt == M_PULSE) begin
            state      <= HOLD;
            cnt        <= '0;
            LCD_ENABLE <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt == M_HOLD) begin
            state <= WAIT;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (cnt == wait_m) begin
            cnt <= '0;
            if (idx == LAST_INIT) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              init_done <= 1'b1;
            end else begin
              state               <= SETUP;
              idx                 <= idx + 3'd1;
              LCD_DATA_BIT        <= init_byte(idx + 3'd1);
              LCD_REGISTER_SELECT <= 1'b0;
              wait_m              <= init_wait(idx + 3'd1);
            end
          end
        end
        IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            state               <= SETUP;
            req_ready           <= 1'b0;
            LCD_DATA_BIT        <= req_data;
            LCD_REGISTER_SELECT <= req_rs;
            wait_m              <= user_wait(req_rs, req_data);
          end
        end
        default: begin
          state <= POWERUP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: init replay, table vectors,
// randomized writes against a pulse-level scoreboard, reset corners.
module tb_lcd_write_sequencer;

  localparam int T_POWERUP = 20;
  localparam int T_INIT1   = 10;
  localparam int T_INIT2   = 5;
  localparam int T_SETUP   = 2;
  localparam int T_PULSE   = 4;
  localparam int T_HOLD    = 1;
  localparam int T_EXEC    = 8;
  localparam int T_CLEAR   = 30;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs    = 1'b0;
  logic [7:0] req_data  = 8'h00;
  logic       req_ready;
  logic       init_done;
  logic [7:0] lcd_data;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;

  lcd_write_sequencer #(
    .T_POWERUP(T_POWERUP),
    .T_INIT1  (T_INIT1),
    .T_INIT2  (T_INIT2),
    .T_SETUP  (T_SETUP),
    .T_PULSE  (T_PULSE),
    .T_HOLD   (T_HOLD),
    .T_EXEC   (T_EXEC),
    .T_CLEAR  (T_CLEAR)
  ) dut (
    .CLOCK_50MHZ        (clk),
    .BUTTON_SOUTH       (rst),
    .req_valid          (req_valid),
    .req_rs             (req_rs),
    .req_data           (req_data),
    .req_ready          (req_ready),
    .init_done          (init_done),
    .LCD_DATA_BIT       (lcd_data),
    .LCD_ENABLE         (lcd_e),
    .LCD_REGISTER_SELECT(lcd_rs),
    .LCD_READ_WRITE     (lcd_rw)
  );

  always #5 clk = ~clk;

  int   cyc   = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         width;
  } pulse_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } vec_t;

  pulse_t     pulse_q[$];
  pulse_t     cur;
  logic [8:0] exp_q[$];
  logic       prev_e    = 1'b0;
  logic       prev_rs   = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         in_pulse  = 1'b0;
  int         rw_bad    = 0;
  int         total     = 0;
  int         bad       = 0;
  int         rc;

  logic [7:0] init_bytes [7] = '{8'h38, 8'h38, 8'h38, 8'h38,
                                 8'h06, 8'h0C, 8'h01};
  int init_waits [7] = '{T_INIT1, T_INIT2, T_EXEC, T_EXEC,
                         T_EXEC, T_EXEC, T_CLEAR};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  function automatic int gap_of(input logic rs, input logic [7:0] d);
    int w;
    w = (!rs && d >= 8'd1 && d <= 8'd3) ? T_CLEAR : T_EXEC;
    return 1 + T_SETUP + T_PULSE + T_HOLD + w;
  endfunction

  // pulse monitor: bus must be stable before, during and just after E
  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_bad++;
    if (rst_q) begin
      in_pulse = 1'b0;
    end else if (lcd_e && !prev_e) begin
      chk("setup_stable", {lcd_rs, lcd_data}, {prev_rs, prev_data});
      cur.rs    = lcd_rs;
      cur.data  = lcd_data;
      cur.rise  = cyc;
      cur.width = 0;
      in_pulse  = 1'b1;
    end else if (in_pulse) begin
      chk("hold_stable", {lcd_rs, lcd_data}, {cur.rs, cur.data});
      if (!lcd_e && prev_e) begin
        cur.width = cyc - cur.rise;
        pulse_q.push_back(cur);
      end else if (!lcd_e) begin
        in_pulse = 1'b0;
      end
    end
    prev_e    = lcd_e;
    prev_rs   = lcd_rs;
    prev_data = lcd_data;
  end

  task automatic wait_ready(input string nm, input int lim);
    int n = 0;
    while (!req_ready && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset(input int n, output int rcyc);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    chk("reset_outputs",
        {lcd_e, lcd_rs, lcd_rw, req_ready, init_done, lcd_data}, 0);
    rcyc      = cyc;
    rst       = 1'b0;
    req_valid = 1'b0;
    pulse_q.delete();
  endtask

  task automatic check_init(input int rcyc);
    int n = 0;
    int early = 0;
    int t;
    while (!init_done && n < 2000) begin
      if (req_ready) early++;
      @(negedge clk);
      n++;
    end
    if (!init_done) begin
      chk("init_timeout", 0, 1);
      return;
    end
    t = T_POWERUP;
    for (int i = 0; i < 7; i++)
      t += T_SETUP + T_PULSE + T_HOLD + init_waits[i];
    chk("init_done_time", cyc - rcyc, t);
    chk("ready_with_done", int'(req_ready), 1);
    chk("no_early_ready", early, 0);
    chk("init_pulses", pulse_q.size(), 7);
    t = T_POWERUP;
    for (int i = 0; i < 7 && i < pulse_q.size(); i++) begin
      chk($sformatf("init%0d_data", i), pulse_q[i].data, init_bytes[i]);
      chk($sformatf("init%0d_rs", i), int'(pulse_q[i].rs), 0);
      chk($sformatf("init%0d_rise", i), pulse_q[i].rise - rcyc,
          t + T_SETUP);
      chk($sformatf("init%0d_width", i), pulse_q[i].width, T_PULSE);
      t += T_SETUP + T_PULSE + T_HOLD + init_waits[i];
    end
    pulse_q.delete();
  endtask

  vec_t vecs [9];
  int   acc  [9];

  initial begin
    int  n;
    int  last_acc;
    int  exp_gap;
    bit  pend;

    vecs[0] = '{1'b1, 8'h41, 16};
    vecs[1] = '{1'b0, 8'h01, 38};
    vecs[2] = '{1'b0, 8'h80, 16};
    vecs[3] = '{1'b1, 8'h01, 16};
    vecs[4] = '{1'b0, 8'h02, 38};
    vecs[5] = '{1'b0, 8'h03, 38};
    vecs[6] = '{1'b0, 8'h00, 16};
    vecs[7] = '{1'b0, 8'h04, 16};
    vecs[8] = '{1'b1, 8'h03, 16};

    do_reset(3, rc);
    check_init(rc);

    // table vectors, valid held back to back
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_rs    = vecs[i].rs;
      req_data  = vecs[i].data;
      wait_ready($sformatf("vec%0d", i), 100);
      acc[i] = cyc + 1;
      if (i > 0)
        chk($sformatf("gap%0d", i - 1), acc[i] - acc[i-1], vecs[i-1].gap);
      @(negedge clk);
      chk($sformatf("ready_drop%0d", i), int'(req_ready), 0);
      chk($sformatf("bus_at_accept%0d", i), {lcd_rs, lcd_data},
          {vecs[i].rs, vecs[i].data});
    end
    req_valid = 1'b0;
    wait_ready("vec_last", 100);
    chk("gap8", cyc + 1 - acc[8], vecs[8].gap);
    chk("vec_pulses", pulse_q.size(), 9);
    for (int i = 0; i < 9 && i < pulse_q.size(); i++) begin
      chk($sformatf("vec%0d_bus", i), {pulse_q[i].rs, pulse_q[i].data},
          {vecs[i].rs, vecs[i].data});
      chk($sformatf("vec%0d_e_start", i), pulse_q[i].rise + 1 - acc[i], 3);
      chk($sformatf("vec%0d_width", i), pulse_q[i].width, 4);
    end
    pulse_q.delete();

    // random writes, bytes toggling every cycle while busy
    pend     = 1'b0;
    last_acc = 0;
    exp_gap  = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (req_ready && pend) begin
        chk("rand_gap", cyc + 1 - last_acc, exp_gap);
        pend = 1'b0;
      end
      req_valid = 1'($urandom_range(0, 1));
      req_rs    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        req_data = 8'($urandom_range(0, 3));
      else
        req_data = 8'($urandom);
      if (req_ready && req_valid) begin
        exp_q.push_back({req_rs, req_data});
        last_acc = cyc + 1;
        exp_gap  = gap_of(req_rs, req_data);
        pend     = 1'b1;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready("rand_end", 100);
    if (pend) chk("rand_gap_last", cyc + 1 - last_acc, exp_gap);
    chk("rand_pulses", pulse_q.size(), exp_q.size());
    n = 0;
    while (pulse_q.size() > 0 && exp_q.size() > 0) begin
      pulse_t p;
      logic [8:0] e;
      p = pulse_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("rand%0d_bus", n), {p.rs, p.data}, e);
      chk($sformatf("rand%0d_width", n), p.width, T_PULSE);
      n++;
    end
    pulse_q.delete();
    exp_q.delete();

    // reset while E is high
    @(negedge clk);
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h55;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!lcd_e && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!lcd_e) chk("mid_pulse_timeout", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_pulse_reset",
        {lcd_e, lcd_rs, req_ready, init_done, lcd_data}, 0);
    rc  = cyc;
    rst = 1'b0;
    pulse_q.delete();
    check_init(rc);

    // reset in the same cycle as an acceptance
    @(negedge clk);
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h77;
    rst       = 1'b1;
    @(negedge clk);
    chk("accept_vs_reset",
        {lcd_e, lcd_rs, req_ready, init_done, lcd_data}, 0);
    rc        = cyc;
    rst       = 1'b0;
    req_valid = 1'b0;
    pulse_q.delete();
    check_init(rc);

    chk("rw_zero", rw_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
